// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the scrubbed register file: default geometry,
//   the CLEAR/RUN state encoding and the index of the last scrubbed entry.
package regfile_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_ADDR_W = 5;

  // CLEAR: storage is being zeroed, file unusable. RUN: normal operation.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } scrub_state_e;

  // Highest entry index for a given address width (2^aw - 1).
  function automatic int last_scrub_idx(input int aw);
    return (1 << aw) - 1;
  endfunction

  localparam int LAST_SCRUB_IDX = last_scrub_idx(DEFAULT_ADDR_W);

endpackage

// File: rtl/regfile_scrub_fsm.sv
// regfile_scrub_fsm
//   Reset scrub sequencer. After every reset it walks entries 1..2^ADDR_W-1,
//   asking the top level to clear one entry per clock, then enters RUN and
//   raises ready. Entry 0 is never stored, so the walk starts at 1.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   ready      out  high in RUN (scrub complete)
//   scrub_we   out  request to clear entry scrub_addr this cycle
//   scrub_addr out  entry to clear (ClrPtr)
//   state      out  current sequencer state, for observation
module regfile_scrub_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  output logic              scrub_we,
  output logic [ADDR_W-1:0] scrub_addr,
  output scrub_state_e      state
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(last_scrub_idx(ADDR_W));

  scrub_state_e      state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  // State register and clear pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= ADDR_W'(1);
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state: advance the pointer each CLEAR cycle; leave CLEAR on the
  // cycle that clears the last entry.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Outputs depend on registered state only, so ready moves on edges only.
  always_comb begin
    ready      = 1'b0;
    scrub_we   = 1'b0;
    scrub_addr = clr_ptr_q;
    case (state_q)
      CLEAR:   scrub_we = 1'b1;
      RUN:     ready    = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/regfile_scrub.sv
// regfile_scrub
//   2-read / 1-write register file, 2^ADDR_W x WIDTH, register 0 reads as 0.
//   After reset the storage is scrubbed to zero one entry per cycle; Ready
//   rises when the file is usable. Reads are combinational.
// Handshake: there is no valid/ready pairing on writes; a write is accepted
//   on any rising edge where Ready=1, RegWrite=1 and WriteRegister!=0.
//   While Ready=0 writes are ignored and both read ports return 0.
// Ports:
//   Clk, Reset_n            clock and synchronous active-low reset
//   ReadRegister1/2         read addresses
//   ReadData1/2             read data (combinational)
//   WriteRegister/WriteData write address and data
//   RegWrite                write enable, active high
//   Ready                   scrub complete
// Build option: define REGFILE_BYPASS_EN to forward WriteData to a read port
//   addressing the register being written in the same cycle (RUN only).
module regfile_scrub
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic              RegWrite,
  output logic              Ready
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              scrub_we;
  logic [ADDR_W-1:0] scrub_addr;
  scrub_state_e      state;

  regfile_scrub_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .ready      (Ready),
    .scrub_we   (scrub_we),
    .scrub_addr (scrub_addr),
    .state      (state)
  );

  logic [WIDTH-1:0] mem [DEPTH];

  logic              user_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;

  // Scrub has priority; user writes are only possible once in RUN anyway.
  // Nothing is stored on a reset edge: the contents are being discarded.
  assign user_we   = (state == RUN) && RegWrite && (WriteRegister != '0);
  assign mem_we    = Reset_n && (scrub_we || user_we);
  assign mem_addr  = scrub_we ? scrub_addr : WriteRegister;
  assign mem_wdata = scrub_we ? '0 : WriteData;

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Read port 1.
  always_comb begin
    ReadData1 = '0;
    if ((state == RUN) && (ReadRegister1 != '0)) begin
      ReadData1 = mem[ReadRegister1];
`ifdef REGFILE_BYPASS_EN
      if (user_we && (ReadRegister1 == WriteRegister)) begin
        ReadData1 = WriteData;
      end
`endif
    end
  end

  // Read port 2.
  always_comb begin
    ReadData2 = '0;
    if ((state == RUN) && (ReadRegister2 != '0)) begin
      ReadData2 = mem[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
      if (user_we && (ReadRegister2 == WriteRegister)) begin
        ReadData2 = WriteData;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_scrub.sv
module tb_regfile_scrub;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] ReadData1, ReadData2, WriteData;
  logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
  logic        RegWrite;
  logic        Ready;

  int checks = 0;
  int errors = 0;

  // Clock / reset block
  always #5 Clk = ~Clk;

  regfile_scrub dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .WriteRegister (WriteRegister),
    .RegWrite      (RegWrite),
    .Ready         (Ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge Clk);
    RegWrite      = 1'b1;
    WriteRegister = a;
    WriteData     = d;
    @(posedge Clk);
    #1;
    @(negedge Clk);
    RegWrite = 1'b0;
  endtask

  task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2);
    @(negedge Clk);
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    #1;
  endtask

  // Counts edges after reset release until Ready, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!Ready && n < 40) begin
      @(posedge Clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    Reset_n       = 1'b0;
    RegWrite      = 1'b0;
    WriteData     = '0;
    WriteRegister = '0;
    ReadRegister1 = 5'd31;
    ReadRegister2 = 5'd5;

    // Reset held for two edges
    repeat (2) @(posedge Clk);
    #1;
    check("reset_ready", {31'b0, Ready}, 32'd0);
    check("reset_rd1", ReadData1, 32'd0);
    check("reset_rd2", ReadData2, 32'd0);

    // Release; attempt a write during CLEAR which must be ignored
    @(negedge Clk);
    Reset_n       = 1'b1;
    RegWrite      = 1'b1;
    WriteRegister = 5'd5;
    WriteData     = 32'h0000_00AA;
    for (int e = 1; e <= 31; e++) begin
      @(posedge Clk);
      #1;
      if (e < 31) begin
        check($sformatf("scrub_ready_e%0d", e), {31'b0, Ready}, 32'd0);
        check($sformatf("scrub_rd1_e%0d", e), ReadData1, 32'd0);
        check($sformatf("scrub_rd2_e%0d", e), ReadData2, 32'd0);
      end else begin
        check("scrub_ready_e31", {31'b0, Ready}, 32'd1);
      end
    end
    @(negedge Clk);
    RegWrite = 1'b0;
    #1;
    check("clear_write_ignored_r5", ReadData2, 32'd0);
    check("scrubbed_r31", ReadData1, 32'd0);

    // Basic write/read
    write_reg(5'd5, 32'd9);
    set_reads(5'd5, 5'd5);
    check("basic_rd1", ReadData1, 32'd9);
    check("basic_rd2", ReadData2, 32'd9);

    // Write disable
    @(negedge Clk);
    RegWrite      = 1'b0;
    WriteRegister = 5'd10;
    WriteData     = 32'd12;
    @(posedge Clk);
    #1;
    set_reads(5'd10, 5'd5);
    check("wdis_r10", ReadData1, 32'd0);
    check("wdis_r5_kept", ReadData2, 32'd9);

    // Decoder isolation
    write_reg(5'd2, 32'd22);
    write_reg(5'd3, 32'd23);
    set_reads(5'd2, 5'd3);
    check("iso_r2", ReadData1, 32'd22);
    check("iso_r3", ReadData2, 32'd23);
    set_reads(5'd1, 5'd4);
    check("iso_r1", ReadData1, 32'd0);
    check("iso_r4", ReadData2, 32'd0);

    // Register zero
    write_reg(5'd0, 32'hDEAD_BEEF);
    set_reads(5'd0, 5'd0);
    check("r0_rd1", ReadData1, 32'd0);
    check("r0_rd2", ReadData2, 32'd0);
    set_reads(5'd5, 5'd2);
    check("r0_no_alias_r5", ReadData1, 32'd9);
    check("r0_no_alias_r2", ReadData2, 32'd22);

    // Pre-edge read of a register being written, then post-edge
    set_reads(5'd4, 5'd3);
    @(negedge Clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd4;
    WriteData     = 32'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("preedge_r4", ReadData1, 32'd7);
`else
    check("preedge_r4", ReadData1, 32'd0);
`endif
    check("preedge_other_port_r3", ReadData2, 32'd23);
    @(posedge Clk);
    #1;
    @(negedge Clk);
    RegWrite = 1'b0;
    #1;
    check("postedge_r4", ReadData1, 32'd7);

    // Fill r31, then reset mid-RUN
    write_reg(5'd31, 32'hFFFF_FFFF);
    set_reads(5'd31, 5'd5);
    check("r31_written", ReadData1, 32'hFFFF_FFFF);
    @(negedge Clk);
    Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    check("midrun_reset_ready", {31'b0, Ready}, 32'd0);
    check("midrun_reset_rd1", ReadData1, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Reset again partway through the scrub; it must restart from the top
    repeat (10) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    wait_ready(n);
    check("rescrub_latency", n, 32'd31);
    check("rescrub_ready", {31'b0, Ready}, 32'd1);
    set_reads(5'd31, 5'd5);
    check("rescrub_r31", ReadData1, 32'd0);
    check("rescrub_r5", ReadData2, 32'd0);
    set_reads(5'd2, 5'd4);
    check("rescrub_r2", ReadData1, 32'd0);
    check("rescrub_r4", ReadData2, 32'd0);

    // Usable again after rescrub
    write_reg(5'd17, 32'h1234_5678);
    set_reads(5'd17, 5'd16);
    check("after_rescrub_r17", ReadData1, 32'h1234_5678);
    check("after_rescrub_r16", ReadData2, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
